// File: rtl/sbus_master.sv
// Single-outstanding initiator for the simple bus: one command in, one bus cycle out, one response back.
// A per-transfer watchdog aborts cycles that never see rdy_ and reports them with rsp_err.
module sbus_master #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // Valid/ready on both ports: a transfer happens on the rising clk edge where
  // valid and ready are both high; the sender holds valid and payload until then.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rd_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              as_,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_,
  output logic [1:0]        dbg_state
);

  localparam logic READ     = 1'b1;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rd_data_d;
  logic              rsp_err_d;
  logic              busy_d;
  logic              as_d;
  logic              rw_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              req_done;
  logic              req_abort;

  assign dbg_state = state;
  assign req_done  = (state == REQ) && !rdy_;
  assign req_abort = (state == REQ) && rdy_ && (cnt == CNT_LAST);

  // State and every output are registers; reset forces the bus idle and drops any response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rd_data <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      as_         <= DISABLE_;
      rw          <= READ;
      addr        <= '0;
      wr_data     <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rd_data <= rsp_rd_data_d;
      rsp_err     <= rsp_err_d;
      busy        <= busy_d;
      as_         <= as_d;
      rw          <= rw_d;
      addr        <= addr_d;
      wr_data     <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_valid) state_d = REQ;
      REQ:     if (req_done || req_abort) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt;
    rsp_rd_data_d = rsp_rd_data;
    rsp_err_d     = rsp_err;
    as_d          = as_;
    rw_d          = rw;
    addr_d        = addr;
    wr_data_d     = wr_data;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          as_d      = ENABLE_;
          rw_d      = cmd_rw;
          addr_d    = cmd_addr;
          wr_data_d = cmd_wr_data;
          cnt_d     = '0;
        end
      end
      REQ: begin
        if (req_done || req_abort) begin
          // rdy_ wins over the abort when both land on the same cycle.
          rsp_rd_data_d = (req_done && (rw == READ)) ? rd_data : '0;
          rsp_err_d     = !req_done;
          as_d          = DISABLE_;
          rw_d          = READ;
          addr_d        = '0;
          wr_data_d     = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: ;
    endcase

    // RESP followed by IDLE keeps as_ high for at least two cycles, so the
    // slave's lingering rdy_ from the previous cycle never reaches REQ.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_sbus_master.sv
// Bench for sbus_master: GPIO-style slave with programmable wait states, a transfer-level
// reference model of the expected responses and latencies, and one task per scenario.
module tb_sbus_master;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic [ADDR_W-1:0] GPIO_ADDR_IN_DATA  = 30'd0;
  localparam logic [ADDR_W-1:0] GPIO_ADDR_OUT_DATA = 30'd1;
  localparam logic [ADDR_W-1:0] GPIO_ADDR_DIR      = 30'd2;
  localparam logic [ADDR_W-1:0] UNMAPPED_ADDR      = 30'h100;
  localparam logic [DATA_W-1:0] WRITE_ECHO         = 32'hDEAD_BEEF;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rd_data;
  logic              rsp_err;
  logic              busy;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_;
  logic [1:0]        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test sequence to finish");
    $fatal(1, "watchdog");
  end

  sbus_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_wr_data(cmd_wr_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd_data(rsp_rd_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .as_        (as_),
    .rw         (rw),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rdy_       (rdy_),
    .dbg_state  (dbg_state)
  );

  // ---------------- GPIO-style slave with wait states ----------------
  logic [DATA_W-1:0] gpio_in;
  logic [DATA_W-1:0] gpio_out;
  logic [DATA_W-1:0] gpio_dir;
  logic [DATA_W-1:0] slv_rd;
  logic              slv_rdy_;
  logic              cs_;
  int                slv_wait;
  int                wcnt;

  assign cs_     = |addr[ADDR_W-1:4];
  assign rdy_    = slv_rdy_;
  assign rd_data = slv_rd;

  always @(posedge clk) begin
    if (rst) begin
      slv_rdy_ <= 1'b1;
      wcnt     <= 0;
      slv_rd   <= '0;
      gpio_out <= '0;
      gpio_dir <= '0;
    end else if (!cs_ && !as_) begin
      if (wcnt >= slv_wait) begin
        slv_rdy_ <= 1'b0;
        if (rw == WRITE) begin
          slv_rd <= WRITE_ECHO;
          if (addr[1:0] == 2'd1) gpio_out <= wr_data;
          else if (addr[1:0] == 2'd2) gpio_dir <= wr_data;
        end else begin
          case (addr[1:0])
            2'd0:    slv_rd <= gpio_in;
            2'd1:    slv_rd <= gpio_out;
            2'd2:    slv_rd <= gpio_dir;
            default: slv_rd <= '0;
          endcase
        end
      end else begin
        slv_rdy_ <= 1'b1;
        wcnt     <= wcnt + 1;
      end
    end else begin
      slv_rdy_ <= 1'b1;
      wcnt     <= 0;
    end
  end

  // ---------------- bus monitor ----------------
  int                       low_run      = 0;
  int                       high_run     = 0;
  int                       last_low_len = 0;
  int                       min_gap      = 1000;
  int                       rsp_rise_cnt = 0;
  logic                     rsp_at_rise  = 1'b0;
  logic                     prev_valid   = 1'b0;
  logic                     bus_unstable = 1'b0;
  logic                     seen_xfer    = 1'b0;
  logic                     mon_clear    = 1'b0;
  logic [ADDR_W+DATA_W:0]   start_bus    = '0;

  always @(posedge clk) begin
    #1;
    if (as_ === 1'b0) begin
      low_run  <= low_run + 1;
      high_run <= 0;
      if (low_run == 0) begin
        start_bus <= {rw, addr, wr_data};
        if (seen_xfer && high_run < min_gap) min_gap <= high_run;
        seen_xfer <= 1'b1;
      end else if ({rw, addr, wr_data} !== start_bus) begin
        bus_unstable <= 1'b1;
      end
    end else begin
      if (low_run > 0) begin
        last_low_len <= low_run;
        rsp_at_rise  <= rsp_valid;
      end
      low_run  <= 0;
      high_run <= high_run + 1;
    end
    if (rsp_valid && !prev_valid) rsp_rise_cnt <= rsp_rise_cnt + 1;
    prev_valid <= rsp_valid;
    if (mon_clear) begin
      min_gap      <= 1000;
      bus_unstable <= 1'b0;
      seen_xfer    <= 1'b0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [DATA_W-1:0] m_out;
  logic [DATA_W-1:0] m_dir;
  logic [DATA_W:0]   exp_q[$];

  // A decoded slave answers after wt wait states; the transfer succeeds when the
  // answer arrives within the TIMEOUT window, otherwise it is an error.
  task automatic model_xfer(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int wt, output logic [DATA_W-1:0] ed, output logic ee, output int el);
    int sel;
    sel = int'(a % 4);
    ed  = '0;
    if (!(a < 16) || (wt + 2 > TIMEOUT)) begin
      ee = 1'b1;
      el = TIMEOUT;
    end else begin
      ee = 1'b0;
      el = wt + 2;
      if (r == WRITE) begin
        if (sel == 1) m_out = d;
        else if (sel == 2) m_dir = d;
      end else begin
        case (sel)
          0:       ed = gpio_in;
          1:       ed = m_out;
          2:       ed = m_dir;
          default: ed = '0;
        endcase
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    n           = 0;
    cmd_rw      = r;
    cmd_addr    = a;
    cmd_wr_data = d;
    cmd_valid   = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_mon_clear;
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    tests_run++; if (rsp_rd_data !== '0) begin tests_failed++; $display("FAIL reset_rsp_rd_data: got %h, required 0", rsp_rd_data); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests_run++; if (as_ !== 1'b1) begin tests_failed++; $display("FAIL reset_as: got %b, required 1", as_); end
    tests_run++; if (rw !== READ) begin tests_failed++; $display("FAIL reset_rw: got %b, required %b", rw, READ); end
    tests_run++; if (addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got %h, required 0", addr); end
    tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL reset_wr_data: got %h, required 0", wr_data); end
    tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d, required 0 (IDLE)", dbg_state); end
    rst   = 1'b0;
    m_out = '0;
    m_dir = '0;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait;
    gpio_in  = 32'h0000_00A5;
    slv_wait = 0;
    send_cmd(READ, GPIO_ADDR_IN_DATA, $urandom);
    wait_valid();
    tests_run++; if (rsp_rd_data !== 32'h0000_00A5) begin tests_failed++; $display("FAIL zw_rd_data: got %h, required 000000a5", rsp_rd_data); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL zw_err: got %b, required 0", rsp_err); end
    tests_run++; if (last_low_len !== 2) begin tests_failed++; $display("FAIL zw_as_low: got %0d cycles, required 2", last_low_len); end
    tests_run++; if (rsp_at_rise !== 1'b1) begin tests_failed++; $display("FAIL zw_rsp_with_as: rsp_valid=%b when as_ rose, required 1", rsp_at_rise); end
    consume();
  endtask

  task automatic test_write_readback;
    slv_wait = 0;
    m_out    = 32'h0000_003C;
    send_cmd(WRITE, GPIO_ADDR_OUT_DATA, 32'h0000_003C);
    wait_valid();
    tests_run++; if (rsp_rd_data !== '0) begin tests_failed++; $display("FAIL wr_rd_data: got %h, required 0", rsp_rd_data); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL wr_err: got %b, required 0", rsp_err); end
    tests_run++; if (gpio_out !== 32'h0000_003C) begin tests_failed++; $display("FAIL wr_gpio_out: got %h, required 0000003c", gpio_out); end
    consume();
    send_cmd(READ, GPIO_ADDR_OUT_DATA, '0);
    wait_valid();
    tests_run++; if (rsp_rd_data !== 32'h0000_003C) begin tests_failed++; $display("FAIL rb_rd_data: got %h, required 0000003c", rsp_rd_data); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rb_err: got %b, required 0", rsp_err); end
    consume();
  endtask

  task automatic test_wait_backpressure;
    logic [DATA_W-1:0] ed;
    logic              ee;
    int                el;
    gpio_in  = $urandom;
    slv_wait = 3;
    pulse_mon_clear();
    model_xfer(READ, GPIO_ADDR_IN_DATA, '0, 3, ed, ee, el);
    send_cmd(READ, GPIO_ADDR_IN_DATA, '0);
    wait_valid();
    tests_run++; if (last_low_len !== el) begin tests_failed++; $display("FAIL ws_as_low: got %0d cycles, required %0d", last_low_len, el); end
    tests_run++; if (bus_unstable !== 1'b0) begin tests_failed++; $display("FAIL ws_bus_stable: changed=%b during as_ low, required 0", bus_unstable); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rd_data !== ed || rsp_err !== ee || cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h err=%b cmd_ready=%b, required 1 %h %b 0",
                 i, rsp_valid, rsp_rd_data, rsp_err, cmd_ready, ed, ee);
      end
    end
    consume();
    tests_run++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready); end
    slv_wait = 0;
  endtask

  task automatic test_timeout;
    int rises0;
    rises0   = rsp_rise_cnt;
    slv_wait = 0;
    send_cmd(READ, UNMAPPED_ADDR, '0);
    wait_valid();
    tests_run++; if (last_low_len !== TIMEOUT) begin tests_failed++; $display("FAIL to_as_low: got %0d cycles, required %0d", last_low_len, TIMEOUT); end
    tests_run++; if (rsp_err !== 1'b1 || rsp_rd_data !== '0) begin tests_failed++; $display("FAIL to_rsp: got err=%b data=%h, required 1 0", rsp_err, rsp_rd_data); end
    consume();
    // slave answers one cycle after the abort
    slv_wait = TIMEOUT - 1;
    gpio_in  = $urandom;
    send_cmd(READ, GPIO_ADDR_IN_DATA, '0);
    wait_valid();
    tests_run++; if (rsp_err !== 1'b1 || rsp_rd_data !== '0 || last_low_len !== TIMEOUT) begin tests_failed++; $display("FAIL to_late: got err=%b data=%h low=%0d, required 1 0 %0d", rsp_err, rsp_rd_data, last_low_len, TIMEOUT); end
    repeat (3) @(negedge clk);
    consume();
    repeat (4) @(negedge clk);
    tests_run++; if (rsp_rise_cnt !== rises0 + 2) begin tests_failed++; $display("FAIL to_no_extra: got %0d responses, required %0d", rsp_rise_cnt - rises0, 2); end
    // slave answering on the last allowed cycle still succeeds
    slv_wait = TIMEOUT - 2;
    send_cmd(READ, GPIO_ADDR_IN_DATA, '0);
    wait_valid();
    tests_run++; if (rsp_err !== 1'b0 || rsp_rd_data !== gpio_in || last_low_len !== TIMEOUT) begin tests_failed++; $display("FAIL to_edge: got err=%b data=%h low=%0d, required 0 %h %0d", rsp_err, rsp_rd_data, last_low_len, gpio_in, TIMEOUT); end
    consume();
    slv_wait = 0;
    send_cmd(READ, GPIO_ADDR_OUT_DATA, '0);
    wait_valid();
    tests_run++; if (rsp_err !== 1'b0 || rsp_rd_data !== m_out) begin tests_failed++; $display("FAIL to_recover: got err=%b data=%h, required 0 %h", rsp_err, rsp_rd_data, m_out); end
    consume();
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] ed;
    logic              ee;
    logic [DATA_W:0]   e;
    int                el;
    int                idx;
    int                got;
    int                n;
    int                last_t;
    bit                pending;
    slv_wait = 0;
    pulse_mon_clear();
    idx = 0; got = 0; n = 0; last_t = -1; pending = 0;
    rsp_ready   = 1'b1;
    cmd_rw      = WRITE;
    cmd_addr    = GPIO_ADDR_OUT_DATA + 30'($urandom_range(0, 1));
    cmd_wr_data = $urandom;
    cmd_valid   = 1'b1;
    while (got < 16 && n < 400) begin
      if (cmd_valid && cmd_ready) begin
        model_xfer(cmd_rw, cmd_addr, cmd_wr_data, 0, ed, ee, el);
        exp_q.push_back({ee, ed});
        idx++;
        pending = 1;
      end
      if (rsp_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_extra: got response %h/%b, required none", rsp_rd_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rd_data} !== e) begin
            tests_failed++;
            $display("FAIL b2b_rsp[%0d]: got err=%b data=%h, required err=%b data=%h", got, rsp_err, rsp_rd_data, e[DATA_W], e[DATA_W-1:0]);
          end
        end
        if (last_t >= 0) begin
          tests_run++;
          if (n - last_t !== 4) begin tests_failed++; $display("FAIL b2b_period[%0d]: got %0d cycles, required 4", got, n - last_t); end
        end
        last_t = n;
        got++;
      end
      @(negedge clk);
      n++;
      if (pending) begin
        pending = 0;
        if (idx < 16) begin
          cmd_rw      = (idx % 2 == 0) ? WRITE : READ;
          cmd_addr    = (idx % 2 == 0) ? GPIO_ADDR_OUT_DATA + 30'($urandom_range(0, 1)) : 30'($urandom_range(0, 2));
          cmd_wr_data = $urandom;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tests_run++; if (got !== 16) begin tests_failed++; $display("FAIL b2b_count: got %0d responses, required 16", got); end
    tests_run++; if (min_gap < 2) begin tests_failed++; $display("FAIL b2b_gap: got as_ high %0d cycles, required >= 2", min_gap); end
    tests_run++; if (bus_unstable !== 1'b0) begin tests_failed++; $display("FAIL b2b_bus_stable: changed=%b, required 0", bus_unstable); end
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] ed;
    logic              ee;
    int                el;
    logic              r;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                wt;
    gpio_in = $urandom;
    for (int i = 0; i < 24; i++) begin
      r  = ($urandom_range(0, 1) == 1) ? READ : WRITE;
      a  = ($urandom_range(0, 3) == 0) ? UNMAPPED_ADDR + 30'($urandom_range(0, 255)) : 30'($urandom_range(0, 15));
      d  = $urandom;
      wt = $urandom_range(0, TIMEOUT - 2);
      slv_wait = wt;
      model_xfer(r, a, d, wt, ed, ee, el);
      send_cmd(r, a, d);
      wait_valid();
      tests_run++;
      if (rsp_rd_data !== ed || rsp_err !== ee || last_low_len !== el) begin
        tests_failed++;
        $display("FAIL rnd[%0d]: got data=%h err=%b low=%0d, required %h %b %0d (rw=%b addr=%h wait=%0d)",
                 i, rsp_rd_data, rsp_err, last_low_len, ed, ee, el, r, a, wt);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
    slv_wait = 0;
  endtask

  task automatic test_reset_mid;
    int rises0;
    rises0   = rsp_rise_cnt;
    slv_wait = 5;
    send_cmd(READ, GPIO_ADDR_IN_DATA, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (as_ !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid: got as_=%b valid=%b cmd_ready=%b busy=%b, required 1 0 1 0", as_, rsp_valid, cmd_ready, busy);
    end
    rst   = 1'b0;
    m_out = '0;
    m_dir = '0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++; if (rsp_rise_cnt !== rises0) begin tests_failed++; $display("FAIL rst_no_rsp: got %0d responses, required 0", rsp_rise_cnt - rises0); end
    slv_wait = 0;
    send_cmd(READ, GPIO_ADDR_OUT_DATA, '0);
    wait_valid();
    tests_run++; if (rsp_err !== 1'b0 || rsp_rd_data !== m_out) begin tests_failed++; $display("FAIL rst_recover: got err=%b data=%h, required 0 %h", rsp_err, rsp_rd_data, m_out); end
    consume();
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rw      = READ;
    cmd_addr    = '0;
    cmd_wr_data = '0;
    rsp_ready   = 1'b0;
    gpio_in     = '0;
    slv_wait    = 0;
    m_out       = '0;
    m_dir       = '0;
    @(negedge clk);
    test_reset();
    test_read_zero_wait();
    test_write_readback();
    test_wait_backpressure();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sbus_master.md
# sbus_master

Single-outstanding initiator for the simple bus: accepts read and write commands on a valid/ready command port and drives them onto `simple_bus_io` as the master. It waits for the addressed slave's `rdy_` (GPIO, timer and other peripherals), then returns the read data or write completion on a valid/ready response port. A timeout counter aborts transfers to unresponsive or undecoded addresses and flags them as errors. It sits between a core-side agent (CPU load/store unit, debug bridge) and the bus decoder that generates the slaves' `cs_`.

## Interface
- `ADDR_W`, default 30: bus word-address width.
- `DATA_W`, default 32 (`WORD_DATA_W`): bus data width.
- `TIMEOUT`, default 255: number of `as_`-low cycles without `rdy_` before abort. Legal range 1..65535.

Ports:
- `clk` in, 1: single clock.
- `rst` in, 1: reset, synchronous, active-high.
- `cmd_valid` in, 1: command present.
- `cmd_ready` out, 1: command accepted when high with `cmd_valid`.
- `cmd_rw` in, 1: `READ`/`WRITE` encoding per stddef.
- `cmd_addr` in, `ADDR_W`: target word address.
- `cmd_wr_data` in, `DATA_W`: write data. Ignored for reads.
- `rsp_valid` out, 1: response present.
- `rsp_ready` in, 1: response consumed when high with `rsp_valid`.
- `rsp_rd_data` out, `DATA_W`: read data. 0 for writes and errors.
- `rsp_err` out, 1: transfer timed out.
- `busy` out, 1: state ≠ IDLE.
- `bus` `simple_bus_io.master`: drives `as_`, `rw`, `addr`, `wr_data`; samples `rd_data`.
- `rdy_` in, 1: active-low slave ready, OR-reduced (wired-AND low) by the decoder.

## Operation
- All outputs are registered.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_rd_data`=0, `rsp_err`=0, `busy`=0, `as_`=`DISABLE_` (1), `rw`=`READ`, `addr`=0, `wr_data`=0. The timeout counter resets to 0.
- Reset asserted mid-transfer: on the next edge, `as_` returns high, `rsp_valid` is dropped, and no response is produced.
- FSM states are IDLE, REQ and RESP:
  - **IDLE**: `cmd_ready`=1. On `cmd_valid`, latch rw/addr/wr_data into the bus registers, drive `as_`=0, clear the counter, set `cmd_ready`=0, and go to REQ.
  - **REQ**: hold `as_`, rw, addr and wr_data stable.
    - If `rdy_`==0: capture `bus.rd_data` into `rsp_rd_data` (force 0 on a write), set `rsp_err`=0 and `rsp_valid`=1, drive `as_`=1 and bus fields to idle values, and go to RESP.
    - Else if counter == `TIMEOUT`-1: set `rsp_rd_data`=0, `rsp_err`=1 and `rsp_valid`=1, drive `as_`=1, and go to RESP.
    - Otherwise increment the counter (saturating; width = clog2(TIMEOUT+1)).
  - **RESP**: hold the response. On `rsp_ready`, set `rsp_valid`=0 and `cmd_ready`=1, and go to IDLE.
- `rdy_` is ignored outside REQ.
- `cmd_ready` is never high while `rsp_valid` is high, so exactly one transfer is outstanding.
- Slaves register `rdy_` one cycle after seeing `as_`, so `rdy_` lingers low for one cycle after `as_` rises. The RESP+IDLE sequence guarantees that `as_` stays high for ≥2 cycles between transfers, so a stale `rdy_` is never sampled by the next REQ. This also covers a slave answering late, just after a timeout.

## Timing
- Command accepted at edge E0 → `as_`=0 from E0.
- Zero-wait slave:
  - `rdy_`=0 after E1.
  - Sampled at E2: `rsp_valid`=1 and `as_`=1 from E2.
  - Accept-to-response latency is 2 cycles. Each wait cycle adds 1.
- Timeout: `as_` is low for exactly `TIMEOUT` cycles, and `rsp_valid`/`rsp_err` rise on the edge that ends the last one.
- Back-to-back with `rsp_ready` tied high: RESP 1 cycle + IDLE 1 cycle. The minimum period per zero-wait transfer is 4 cycles.
- `rsp_*` are stable while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan
- **Read, zero wait.** Slave model (GPIO-style, `rdy_` registered from `cs_`&`as_`) has `gpio_in`=0xA5. Read `GPIO_ADDR_IN_DATA` → `as_` low exactly 2 cycles, then `rsp_valid` with `rsp_rd_data`=0x0000_00A5 and `rsp_err`=0.
- **Write then read-back.** Write 0x0000_003C to `GPIO_ADDR_OUT_DATA` → `gpio_out`=0x3C and response with `rsp_rd_data`=0 and `rsp_err`=0. The following read returns 0x3C.
- **Wait states and backpressure.** Slave delays `rdy_` by 3 cycles → `as_` low 5 cycles with addr stable. Hold `rsp_ready`=0 for 4 cycles → response held unchanged and `cmd_ready`=0 throughout.
- **Timeout.** `TIMEOUT`=8, no slave responds → `as_` low exactly 8 cycles, then `rsp_err`=1 and `rsp_rd_data`=0. A slave asserting `rdy_` 1 cycle after the abort causes no extra response. The next command completes normally.
- **Back-to-back.** 16 alternating read/write commands with `cmd_valid`/`rsp_ready` held high → 16 responses in order, 4-cycle period, `as_` high ≥2 cycles between transfers.
- **Reset mid-transfer.** Assert `rst` for 1 cycle while in REQ → `as_`=1 and `rsp_valid`=0 on the next edge, `cmd_ready`=1, and no response is emitted for the aborted command.
